hc595_rx: RTL and testbench



---
 rtl/hc595_rx.sv | 143 ++++++++++++++
 tb/tb_hc595_rx.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/hc595_rx.sv
// Receive-side deserializer for the six-digit 74HC595 display link.
// Optional seven-segment decode buffer is built when HC595_RX_DECODE_EN is defined.
module hc595_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        shcp,
  input  logic        stcp,
  input  logic        ds,
  input  logic        oe,
  output logic [5:0]  sel_o,
  output logic [7:0]  seg_o,
  output logic        blank,
  output logic        frame_vld,
  output logic        frame_err,
  output logic [23:0] digits,
  output logic [5:0]  dps,
  output logic [5:0]  digit_ok
);

  logic [SYNC_STAGES-1:0] ds_q, shcp_q, stcp_q, oe_q;
  logic        shcp_h, stcp_h;
  logic        ds_s, shcp_s, stcp_s;
  logic        shift_rise, latch_rise;
  logic [13:0] sr, sr_nx;
  logic [3:0]  bcnt, bcnt_nx;

  assign ds_s   = ds_q[SYNC_STAGES-1];
  assign shcp_s = shcp_q[SYNC_STAGES-1];
  assign stcp_s = stcp_q[SYNC_STAGES-1];

  // oe chain resets high so the display reads dark until the pin is seen
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      ds_q   <= '0;
      shcp_q <= '0;
      stcp_q <= '0;
      oe_q   <= '1;
      shcp_h <= 1'b0;
      stcp_h <= 1'b0;
      blank  <= 1'b1;
    end else begin
      ds_q   <= {ds_q[SYNC_STAGES-2:0], ds};
      shcp_q <= {shcp_q[SYNC_STAGES-2:0], shcp};
      stcp_q <= {stcp_q[SYNC_STAGES-2:0], stcp};
      oe_q   <= {oe_q[SYNC_STAGES-2:0], oe};
      shcp_h <= shcp_s;
      stcp_h <= stcp_s;
      blank  <= oe_q[SYNC_STAGES-1];
    end
  end

  assign shift_rise = shcp_s & ~shcp_h;
  assign latch_rise = stcp_s & ~stcp_h;

  // shift first, so a coincident latch sees the post-shift frame
  always_comb begin
    sr_nx   = sr;
    bcnt_nx = bcnt;
    if (shift_rise) begin
      sr_nx = {sr[12:0], ds_s};
      if (bcnt != 4'd15) bcnt_nx = bcnt + 4'd1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      sr        <= '0;
      bcnt      <= '0;
      sel_o     <= '0;
      seg_o     <= 8'hFF;
      frame_vld <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      sr        <= sr_nx;
      bcnt      <= bcnt_nx;
      frame_vld <= 1'b0;
      frame_err <= 1'b0;
      if (latch_rise) begin
        bcnt <= '0;
        if (bcnt_nx == 4'd14) begin
          sel_o     <= {sr_nx[8], sr_nx[9], sr_nx[10], sr_nx[11], sr_nx[12], sr_nx[13]};
          seg_o     <= sr_nx[7:0];
          frame_vld <= 1'b1;
        end else begin
          frame_err <= 1'b1;
        end
      end
    end
  end

`ifdef HC595_RX_DECODE_EN
  logic       sel_onehot;
  logic [4:0] dec;

  function automatic logic [4:0] dec7(input logic [6:0] s);
    case ({1'b1, s})
      8'hC0: dec7 = 5'h10;
      8'hF9: dec7 = 5'h11;
      8'hA4: dec7 = 5'h12;
      8'hB0: dec7 = 5'h13;
      8'h99: dec7 = 5'h14;
      8'h92: dec7 = 5'h15;
      8'h82: dec7 = 5'h16;
      8'hF8: dec7 = 5'h17;
      8'h80: dec7 = 5'h18;
      8'h90: dec7 = 5'h19;
      8'h88: dec7 = 5'h1A;
      8'h83: dec7 = 5'h1B;
      8'hC6: dec7 = 5'h1C;
      8'hA1: dec7 = 5'h1D;
      8'h86: dec7 = 5'h1E;
      8'h8E: dec7 = 5'h1F;
      default: dec7 = 5'h00;
    endcase
  endfunction

  assign sel_onehot = (sel_o != 6'd0) && ((sel_o & (sel_o - 6'd1)) == 6'd0);
  assign dec        = dec7(seg_o[6:0]);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      digits   <= '0;
      dps      <= '0;
      digit_ok <= '0;
    end else if (frame_vld && sel_onehot) begin
      for (int k = 0; k < 6; k++) begin
        if (sel_o[k]) begin
          digits[4*k +: 4] <= dec[3:0];
          digit_ok[k]      <= dec[4];
          dps[k]           <= ~seg_o[7];
        end
      end
    end
  end
`else
  assign digits   = '0;
  assign dps      = '0;
  assign digit_ok = '0;
`endif

endmodule

// File: tb/tb_hc595_rx.sv
// Self-checking bench for hc595_rx: frame table, latch scoreboard and corner sequences.
module tb_hc595_rx;
  localparam int SYNC = 2;
`ifdef HC595_RX_DECODE_EN
  localparam bit DEC = 1'b1;
`else
  localparam bit DEC = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, shcp, stcp, ds, oe;
  logic [5:0]  sel_o, dps, digit_ok;
  logic [7:0]  seg_o;
  logic        blank, frame_vld, frame_err;
  logic [23:0] digits;

  hc595_rx #(.SYNC_STAGES(SYNC)) dut (
    .sys_clk(clk), .sys_rst(rst), .shcp(shcp), .stcp(stcp), .ds(ds), .oe(oe),
    .sel_o(sel_o), .seg_o(seg_o), .blank(blank), .frame_vld(frame_vld),
    .frame_err(frame_err), .digits(digits), .dps(dps), .digit_ok(digit_ok)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    bit         vld;
    logic [5:0] sel;
    logic [7:0] seg;
    int         t;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    logic [5:0] sel;
    logic [7:0] seg;
    int         n;
    bit         sim;
    bit         vld;
    logic [5:0] esel;
    logic [7:0] eseg;
  } vec_t;
  vec_t tbl[9];

  logic [23:0] m_digits;
  logic [5:0]  m_dps, m_ok;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [4:0] ref_dec(input logic [7:0] s);
    logic [7:0] codes [16];
    codes = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
              8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    ref_dec = 5'h00;
    for (int i = 0; i < 16; i++)
      if ((s | 8'h80) == codes[i]) ref_dec = {1'b1, 4'(i)};
  endfunction

  function automatic void model_update(input logic [5:0] sel, input logic [7:0] seg);
    logic [4:0] d;
    if (!DEC || $countones(sel) != 1) return;
    d = ref_dec(seg);
    for (int k = 0; k < 6; k++)
      if (sel[k]) begin
        m_digits[4*k +: 4] = d[3:0];
        m_ok[k]            = d[4];
        m_dps[k]           = ~seg[7];
      end
  endfunction

  // Scoreboard: every latch pulse must match the oldest pending expectation
  always @(negedge clk) begin
    if (!rst && (frame_vld || frame_err)) begin
      exp_t e;
      chk("pulse_exclusive", {31'd0, frame_vld & frame_err}, 32'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("pulse_kind_vld", {31'd0, frame_vld}, {31'd0, e.vld});
        chk("sel_o", {26'd0, sel_o}, {26'd0, e.sel});
        chk("seg_o", {24'd0, seg_o}, {24'd0, e.seg});
        chk("latch_latency", cyc - e.t, SYNC + 1);
      end
    end
  end

  function automatic logic [13:0] frame_bits(input logic [5:0] sel, input logic [7:0] seg);
    return {sel[0], sel[1], sel[2], sel[3], sel[4], sel[5], seg};
  endfunction

  task automatic shift_bits(input logic [13:0] fr, input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      ds = fr[13 - (i % 14)];
      repeat (2) @(negedge clk);
      shcp = 1'b1;
      repeat (3) @(negedge clk);
      shcp = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic push(input bit vld, input logic [5:0] sel, input logic [7:0] seg);
    exp_t e;
    e.vld = vld; e.sel = sel; e.seg = seg; e.t = cyc;
    exp_q.push_back(e);
    if (vld) model_update(sel, seg);
  endtask

  task automatic latch(input bit vld, input logic [5:0] sel, input logic [7:0] seg);
    push(vld, sel, seg);
    stcp = 1'b1;
    repeat (3) @(negedge clk);
    stcp = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_frame(input vec_t v);
    logic [13:0] fr;
    fr = frame_bits(v.sel, v.seg);
    if (v.sim) begin
      shift_bits(fr, 0, v.n - 1);
      ds = fr[13 - ((v.n - 1) % 14)];
      repeat (2) @(negedge clk);
      push(v.vld, v.esel, v.eseg);
      shcp = 1'b1;
      stcp = 1'b1;
      repeat (3) @(negedge clk);
      shcp = 1'b0;
      stcp = 1'b0;
      repeat (2) @(negedge clk);
    end else begin
      shift_bits(fr, 0, v.n);
      latch(v.vld, v.esel, v.eseg);
    end
  endtask

  task automatic drain_and_check(input string tag);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
    chk({tag, "_drain"}, exp_q.size(), 0);
    repeat (2) @(negedge clk);
    chk({tag, "_digits"}, {8'd0, digits}, {8'd0, m_digits});
    chk({tag, "_dps"}, {26'd0, dps}, {26'd0, m_dps});
    chk({tag, "_digit_ok"}, {26'd0, digit_ok}, {26'd0, m_ok});
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_sel_o"}, {26'd0, sel_o}, 32'd0);
    chk({tag, "_seg_o"}, {24'd0, seg_o}, 32'hFF);
    chk({tag, "_blank"}, {31'd0, blank}, 32'd1);
    chk({tag, "_pulses"}, {30'd0, frame_vld, frame_err}, 32'd0);
    chk({tag, "_digits"}, {8'd0, digits}, 32'd0);
    chk({tag, "_dps_ok"}, {20'd0, dps, digit_ok}, 32'd0);
  endtask

  initial begin
    logic [13:0] fr;
    vec_t v;
    //          sel       seg    n  sim vld esel      eseg
    tbl[0] = '{6'b000001, 8'hC0, 14, 0, 1, 6'b000001, 8'hC0};
    tbl[1] = '{6'b100000, 8'h19, 14, 0, 1, 6'b100000, 8'h19};
    tbl[2] = '{6'b000100, 8'hA4, 13, 0, 0, 6'b100000, 8'h19};
    tbl[3] = '{6'b000100, 8'hA4, 14, 0, 1, 6'b000100, 8'hA4};
    tbl[4] = '{6'b001000, 8'hB0, 14, 1, 1, 6'b001000, 8'hB0};
    tbl[5] = '{6'b000010, 8'hBF, 14, 0, 1, 6'b000010, 8'hBF};
    tbl[6] = '{6'b010000, 8'h8E, 30, 0, 0, 6'b000010, 8'hBF};
    tbl[7] = '{6'b000011, 8'hF9, 14, 0, 1, 6'b000011, 8'hF9};
    tbl[8] = '{6'b000000, 8'h80, 14, 0, 1, 6'b000000, 8'h80};

    m_digits = '0; m_dps = '0; m_ok = '0;
    rst = 1'b1; shcp = 1'b0; stcp = 1'b0; ds = 1'b0; oe = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_vals("reset");

    for (int i = 0; i < 9; i++) begin
      send_frame(tbl[i]);
      drain_and_check($sformatf("vec%0d", i));
    end

    // Reset in mid-frame: partial bits are discarded
    fr = frame_bits(6'b000001, 8'hC6);
    shift_bits(fr, 0, 7);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    m_digits = '0; m_dps = '0; m_ok = '0;
    @(negedge clk);
    chk_reset_vals("midrst");
    shift_bits(fr, 7, 14);
    latch(1'b0, 6'b000000, 8'hFF);
    drain_and_check("midrst_err");
    chk_reset_vals("midrst_after_err");
    v = '{6'b000001, 8'h88, 14, 0, 1, 6'b000001, 8'h88};
    send_frame(v);
    drain_and_check("post_rst");

    // oe to blank latency
    oe = 1'b0;
    repeat (SYNC) @(negedge clk);
    chk("blank_before", {31'd0, blank}, 32'd1);
    @(negedge clk);
    chk("blank_after", {31'd0, blank}, 32'd0);
    oe = 1'b1;
    repeat (SYNC + 2) @(negedge clk);
    chk("blank_restore", {31'd0, blank}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end
endmodule
